// File: rtl/counters_pkg.sv
// Shared types and constants for the counters-section address controller.
package counters_pkg;

  localparam int AW_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GS   = 2'd1,
    ST_GD   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_S = 1'b0,
    REQ_D = 1'b1
  } req_t;

  localparam int STEP_NARROW = 1;
  localparam int STEP_WIDE   = 2;

endpackage

// File: rtl/addr_step.sv
// Shared address incrementer plus per-bit load/count select (AND-OR form).
module addr_step
  import counters_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] addr,
  input  logic          dir,
  input  logic          wide,
  input  logic          ld,
  input  logic [AW-1:0] lddata,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] stepped;
  logic [AW-1:0] ld_mask;

  assign step    = wide ? AW'(STEP_WIDE) : AW'(STEP_NARROW);
  // Modulo-2^AW arithmetic: wrap in both directions is the intended behaviour.
  assign stepped = dir ? (addr - step) : (addr + step);

  assign ld_mask   = {AW{ld}};
  assign next_addr = (ld_mask & lddata) | (~ld_mask & stepped);

endmodule

// File: rtl/addr_counter_arb.sv
// Source/destination address registers sharing one step datapath; CPU loads
// win over steps, and step requests are granted round-robin.
module addr_counter_arb
  import counters_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RESETL,
  input  logic          LD,
  input  logic          LDSEL,
  input  logic [AW-1:0] LDDATA,
  input  logic          SREQ,
  input  logic          SDIR,
  input  logic          SWIDE,
  input  logic          DREQ,
  input  logic          DDIR,
  input  logic          DWIDE,
  output logic          SGNT,
  output logic          DGNT,
  output logic [AW-1:0] SADDR,
  output logic [AW-1:0] DADDR,
  output logic          BUSY
);

  state_t        state;
  state_t        state_nxt;
  req_t          last;
  req_t          last_nxt;

  logic          op_sel;
  logic          op_dir;
  logic          op_wide;
  logic [AW-1:0] op_addr;
  logic [AW-1:0] wr_data;
  logic          wr_s;
  logic          wr_d;

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state <= ST_IDLE;
      last  <= REQ_D;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // A load always takes the cycle: it stalls a pending grant and masks new requests.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    SGNT      = 1'b0;
    DGNT      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!LD) begin
          if (SREQ && DREQ)
            state_nxt = (last == REQ_D) ? ST_GS : ST_GD;
          else if (SREQ)
            state_nxt = ST_GS;
          else if (DREQ)
            state_nxt = ST_GD;
        end
      end
      ST_GS: begin
        if (!LD) begin
          SGNT      = 1'b1;
          last_nxt  = REQ_S;
          state_nxt = ST_IDLE;
        end
      end
      ST_GD: begin
        if (!LD) begin
          DGNT      = 1'b1;
          last_nxt  = REQ_D;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign BUSY = (state != ST_IDLE);

  // Operand select: load target when loading, otherwise the register in grant.
  assign op_sel  = LD ? LDSEL : (state == ST_GD);
  assign op_dir  = op_sel ? DDIR  : SDIR;
  assign op_wide = op_sel ? DWIDE : SWIDE;
  assign op_addr = op_sel ? DADDR : SADDR;

  addr_step #(
    .AW (AW)
  ) u_step (
    .addr      (op_addr),
    .dir       (op_dir),
    .wide      (op_wide),
    .ld        (LD),
    .lddata    (LDDATA),
    .next_addr (wr_data)
  );

  assign wr_s = LD ? ~LDSEL : SGNT;
  assign wr_d = LD ?  LDSEL : DGNT;

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      SADDR <= '0;
      DADDR <= '0;
    end else begin
      if (wr_s) SADDR <= wr_data;
      if (wr_d) DADDR <= wr_data;
    end
  end

endmodule

// File: doc/addr_counter_arb.md
# addr_counter_arb

Controller and arbiter for the shared address-step datapath in the counters section. It maintains two address registers, source and destination, that share one incrementer and one load/count mux per bit, of the AND-OR select form used throughout the counters netlist. CPU loads have absolute priority. Step requests from the two requesters are granted round-robin, at most one per grant cycle.

## Interface
Parameters:
- AW, 20, address width; registers wrap modulo 2^AW.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESETL  in  1  asynchronous, active-low reset.
- LD  in  1  CPU load strobe, single cycle.
- LDSEL  in  1  load target: 0 = source, 1 = destination.
- LDDATA  in  AW  load value.
- SREQ  in  1  source step request; held high until SGNT.
- SDIR  in  1  source direction: 0 = up, 1 = down.
- SWIDE  in  1  source step size: 0 = 1, 1 = 2.
- DREQ, DDIR, DWIDE  in  1 each  destination equivalents.
- SGNT  out  1  one-cycle grant; the source step is applied at the end of this cycle.
- DGNT  out  1  destination equivalent.
- SADDR  out  AW  source address register.
- DADDR  out  AW  destination address register.
- BUSY  out  1  high when the state is not IDLE.

## Operation
- Step arithmetic: next = addr + step when DIR=0, addr − step when DIR=1. step = 2 if WIDE else 1. Computed in AW bits with silent wrap: 0xFFFFF + 1 → 0x00000, and 0x00000 − 2 → 0xFFFFE.
- DIR and WIDE are sampled in the grant cycle, not the request cycle.
- The FSM has three states: IDLE, GS (grant source) and GD (grant destination).
- IDLE:
  - LD present → apply the load, stay in IDLE. No request is sampled in that cycle.
  - Otherwise, if only one REQ is high → go to its grant state.
  - If both are high → go to the requester that did not win last (LAST pointer).
  - If neither is high → stay in IDLE.
- GS / GD:
  - LD present → apply the load, deassert GNT and hold the state (stall).
  - Otherwise → assert GNT, write the stepped value to the granted register, set LAST to the granted requester, return to IDLE.
  - REQ is ignored in grant states.
- A load to the register being stepped lands first. The step is then applied to the loaded value on the next cycle.
- A load to the other register still stalls the grant; this keeps the rule to one datapath write per cycle.
- Requester protocol: REQ stays high through the GNT cycle. REQ still high in the cycle after GNT counts as a new request.
- Dropping REQ in a grant state does not cancel the step.

## Timing
- Reset values: SADDR = 0, DADDR = 0, SGNT = DGNT = 0, BUSY = 0, state = IDLE, LAST = destination (source wins the first tie).
- Reset asserted mid-operation aborts immediately to the reset values. A pending step is lost. No GNT is issued.
- Load latency: LD in cycle N → new value visible on xADDR in cycle N+1.
- Step latency: REQ first high in IDLE at cycle N → GNT in N+1 (no LD) → stepped value visible in N+2.
- Each LD cycle during a grant state adds one cycle.
- Throughput: one step per 2 cycles. A continuous dual request alternates S, D, S, D…
- GNT is exactly one cycle wide. SGNT and DGNT are never high together.

## Structure
- counters_pkg: AW default, state enum (IDLE, GS, GD), requester encoding (REQ_S = 0, REQ_D = 1), step constants.
- Sub-module addr_step:
  - Combinational shared datapath: selected register in, DIR/WIDE/LD/LDDATA in, next value out.
  - Per-bit load/count select in AND-OR form: LD&LDDATA | ~LD&stepped.
  - Instantiated once; the FSM drives its operand select.

## Test plan
- Reset then idle: RESETL low mid-cycle → all outputs 0 asynchronously. After release, 10 idle cycles → SADDR = DADDR = 0, BUSY = 0.
- Load and single step: LD, LDSEL=0, LDDATA=0x12340 → SADDR = 0x12340 next cycle. SREQ with SDIR=0, SWIDE=1 → SGNT at +1 → SADDR = 0x12342 at +2.
- Round-robin: SREQ and DREQ held high for 8 cycles from reset → grants S, D, S, D on alternate cycles. Each register steps twice by its own DIR/WIDE.
- Wrap: DADDR loaded 0x00001, DDIR=1, DWIDE=1 → DADDR = 0xFFFFF. SADDR loaded 0xFFFFF, SDIR=0, SWIDE=0 → SADDR = 0x00000.
- LD collision: while in GS, LD to source with 0x00100 → SGNT low that cycle, SADDR = 0x00100. Next cycle SGNT high → SADDR = 0x00101 (SWIDE=0, SDIR=0).
- Reset mid-grant: drop RESETL in the GD cycle → DGNT low immediately, DADDR = 0, and no grant is issued after release until a new DREQ arrives.
